md_hash_engine: RTL and testbench
=================================

// Module: md_hash_engine
// PURPOSE
//  Multi-block MD4/MD5 compression engine. Successor to the fixed single-block MD4 core:
//  - streams any number of pre-padded 512-bit blocks over a valid/ready handshake
//  - chains intermediate state between blocks
//  - selects MD4 or MD5 per message
//  - performs ROUNDS_PER_CYCLE steps per clock
//  Sits between the padding/front-end logic and the digest consumer in the hash subsystem.
// PARAMETERS
//  ROUNDS_PER_CYCLE  1  steps per clock; legal values 1,2,4,8 (divide both 48 and 64)
// PORTS
//  clk           in   1    single clock; all state updates on rising edge
//  reset         in   1    synchronous, active-high
//  in_valid      in   1    block_data/first/last/mode are valid
//  in_ready      out  1    engine can accept a block this cycle
//  block_data    in   512  padded block; word M[j] = block_data[511-32*j -: 32], bytes little-endian
//  first         in   1    block starts a new message; chaining state reloads the IV
//  last          in   1    block ends the message; the digest is produced after it
//  mode          in   1    0 = MD4, 1 = MD5; sampled only with first=1
//  digest        out  128  {bswap(A),bswap(B),bswap(C),bswap(D)} in standard hex byte order
//  digest_valid  out  1    one-cycle pulse when digest is updated
//  busy          out  1    high from block accept until the final add completes
// BEHAVIOUR
//  Reset values: in_ready=1, busy=0, digest_valid=0, digest=0, state=IDLE, chain regs=IV.
//  IV: A=67452301 B=efcdab89 C=98badcfe D=10325476.
//  FSM states: IDLE -> RUN -> ADD -> IDLE.
//   - IDLE: in_ready=1. On in_valid:
//     - latch block_data and last
//     - if first=1: load IV and latch mode
//     - if first=0: keep chain regs and the previously latched mode
//     - step counter = 0; go to RUN
//   - RUN: per cycle, apply ROUNDS_PER_CYCLE steps; counter += ROUNDS_PER_CYCLE.
//     Leave RUN when counter reaches 48 (MD4) or 64 (MD5).
//   - ADD: chain += working regs (mod 2^32, per word).
//     If last: digest <= byte-swapped chain and digest_valid pulses this edge. Return to IDLE.
//  Latency from accept edge to the digest_valid edge = N/ROUNDS_PER_CYCLE + 1 cycles (N = 48 or 64).
//  Back-to-back: next accept is possible on the cycle after ADD; in_ready is low in RUN and ADD.
//  MD4 step functions and constants:
//   - F/G/H = (b&c)|(~b&d), (b&c)|(b&d)|(c&d), b^c^d
//   - K = 0, 5a827999, 6ed9eba1
//   - message index: step i; round 2 uses 4*(i%4)+i/4; round 3 uses the bit-reversed order 0,8,4,12,2,10,6,14,...
//   - shifts: {3,7,11,19}, {3,5,9,13}, {3,9,11,15}
//  MD5 step functions and constants:
//   - standard F, G, H, I; T[i] = floor(2^32*|sin(i+1)|)
//   - new B = B + rotl(A + f + M[k] + T, s)
//  All arithmetic is 32-bit wrap-around; no saturation.
//  Boundary conditions:
//   - in_valid while in_ready=0: ignored; the source must hold its inputs.
//   - first=0 after a completed message: chains from the last chain value (caller responsibility).
//   - first=1 and last=1: single-block message.
//   - reset in any state: all outputs return to reset values within one edge; any in-flight block is discarded.
//  digest holds its value until the next digest_valid.
// CONFIGURATION
//  MD_HASH_MD5_EN defined:
//   - MD5 datapath, T table and I function are present; mode selects the algorithm.
//  MD_HASH_MD5_EN undefined:
//   - MD4 only; mode is ignored and treated as 0.
//   - the step counter limit is fixed at 48.
// STRUCTURE
//  Package md_hash_pkg:
//   - IV constants; MD4 K constants; MD5 T[0:63]
//   - shift tables and message-index tables for MD4 and MD5
//   - state enum {IDLE,RUN,ADD}; helper functions rotl32 and bswap32
//  Sub-module md_step:
//   - one combinational step: (a,b,c,d,M[k],K,s,round,mode) -> rotated tuple
//   - instantiated ROUNDS_PER_CYCLE times in a chain
// TESTING
//  1. MD4 "" (block word0=00000080, rest 0), first=last=1, R=1 -> digest 31d6cfe0d16ae931b73c59d7e0c089c0, pulse 49 cycles after accept.
//  2. MD4 "abc" (word0=80636261, word14=00000018) -> a448017aaf21d8525fc10ae87aa6729d; repeat with R=4 -> same digest after 13 cycles.
//  3. MD5 "" -> d41d8cd98f00b204e9800998ecf8427e; MD5 "abc" -> 900150983cd24fb0d6963f7d28e17f72 (MD5_EN defined).
//  4. Two-block MD5 of a 64-byte "a" string: first=1/last=0, then first=0/last=1 -> 014842d480b571495a4a0363793f7367; no pulse after block 1.
//  5. in_valid held high during RUN -> in_ready=0 and the block is not re-accepted; it is accepted exactly once on return to IDLE.
//  6. reset asserted mid-RUN -> next edge busy=0, in_ready=1, digest=0; a following MD4 "" block still gives 31d6cfe0d16ae931b73c59d7e0c089c0.

Source files
------------

// File: rtl/md_hash_pkg.sv
// Shared constants, step tables and helpers for the MD4/MD5 compression engine.
// MD5 constants exist only when MD_HASH_MD5_EN is defined.
package md_hash_pkg;

    typedef enum logic [1:0] {IDLE, RUN, ADD} state_e;

    // Element 0 is A, element 3 is D.
    localparam logic [3:0][31:0] IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};

    localparam logic [31:0] MD4_K0 = 32'h00000000;
    localparam logic [31:0] MD4_K1 = 32'h5a827999;
    localparam logic [31:0] MD4_K2 = 32'h6ed9eba1;

    localparam logic [4:0] MD4_S [3][4] = '{
        '{5'd3, 5'd7, 5'd11, 5'd19},
        '{5'd3, 5'd5, 5'd9,  5'd13},
        '{5'd3, 5'd9, 5'd11, 5'd15}};

    typedef struct packed {
        logic [3:0]  k;
        logic [4:0]  s;
        logic [31:0] kc;
        logic [1:0]  rnd;
    } step_ctl_t;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Round 2 transposes the 4x4 word grid; round 3 bit-reverses the index.
    function automatic step_ctl_t md4_ctl(input logic [5:0] step);
        step_ctl_t  c;
        logic [3:0] j;
        j     = step[3:0];
        c.rnd = step[5:4];
        case (c.rnd)
            2'd1:    begin c.k = {j[1:0], j[3:2]};       c.s = MD4_S[1][j[1:0]]; c.kc = MD4_K1; end
            2'd2:    begin c.k = {j[0], j[1], j[2], j[3]}; c.s = MD4_S[2][j[1:0]]; c.kc = MD4_K2; end
            default: begin c.k = j;                      c.s = MD4_S[0][j[1:0]]; c.kc = MD4_K0; end
        endcase
        return c;
    endfunction

`ifdef MD_HASH_MD5_EN
    localparam logic [4:0] MD5_S [4][4] = '{
        '{5'd7, 5'd12, 5'd17, 5'd22},
        '{5'd5, 5'd9,  5'd14, 5'd20},
        '{5'd4, 5'd11, 5'd16, 5'd23},
        '{5'd6, 5'd10, 5'd15, 5'd21}};

    localparam logic [31:0] MD5_T [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};

    function automatic step_ctl_t md5_ctl(input logic [5:0] step);
        step_ctl_t  c;
        logic [3:0] j;
        j     = step[3:0];
        c.rnd = step[5:4];
        case (c.rnd)
            2'd0:    c.k = j;
            2'd1:    c.k = 4'd5 * j + 4'd1;
            2'd2:    c.k = 4'd3 * j + 4'd5;
            default: c.k = 4'd7 * j;
        endcase
        c.s  = MD5_S[c.rnd][j[1:0]];
        c.kc = MD5_T[step];
        return c;
    endfunction
`endif

endpackage

// File: rtl/md_hash_engine_step.sv
// One combinational MD4/MD5 step; output tuple is rotated so the next step sees (d, new, b, c).
// MD5 functions G/I and the B-relative update exist only with MD_HASH_MD5_EN.
module md_step
    import md_hash_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [31:0]  m_i,
    input  logic [31:0]  kc_i,
    input  logic [4:0]   s_i,
    input  logic [1:0]   rnd_i,
    input  logic         mode_i,
    output logic [127:0] st_o
);
    logic [31:0] a, b, c, d, f, r, nb;

    assign {d, c, b, a} = st_i;

    always_comb begin
        case (rnd_i)
            2'd0:    f = (b & c) | (~b & d);
            2'd1:    f = (b & c) | (b & d) | (c & d);
            default: f = b ^ c ^ d;
        endcase
`ifdef MD_HASH_MD5_EN
        if (mode_i) begin
            case (rnd_i)
                2'd1:    f = (b & d) | (c & ~d);
                2'd3:    f = c ^ (b | ~d);
                default: f = f;
            endcase
        end
`endif
        r  = rotl32(a + f + m_i + kc_i, s_i);
        nb = r;
`ifdef MD_HASH_MD5_EN
        if (mode_i) nb = b + r;
`endif
    end

`ifndef MD_HASH_MD5_EN
    logic unused_mode;
    assign unused_mode = mode_i;
`endif

    assign st_o = {c, b, nb, d};

endmodule

// File: rtl/md_hash_engine.sv
// Multi-block MD4/MD5 compression engine: IDLE -> RUN (N/ROUNDS_PER_CYCLE cycles) -> ADD -> IDLE.
// MD_HASH_MD5_EN enables MD5 selection via mode; otherwise MD4 only with a 48-step limit.
module md_hash_engine
    import md_hash_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_data,
    input  logic         first,
    input  logic         last,
    input  logic         mode,
    output logic [127:0] digest,
    output logic         digest_valid,
    output logic         busy
);
    localparam int R = ROUNDS_PER_CYCLE;

    state_e           state_q, state_d;
    logic [6:0]       cnt_q, cnt_d, limit;
    logic [511:0]     blk_q, blk_d;
    logic             last_q, last_d;
    logic [3:0][31:0] ch_q, ch_d, wk_q, wk_d;
    logic [127:0]     dig_q, dig_d;
    logic             dv_q, dv_d;
    logic             md5_sel;
    logic [31:0]      m_words [16];
    logic [127:0]     stg [R+1];

`ifdef MD_HASH_MD5_EN
    logic mode_q, mode_d;
    assign md5_sel = mode_q;
    assign limit   = mode_q ? 7'd64 : 7'd48;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign md5_sel     = 1'b0;
    assign limit       = 7'd48;
`endif

    always_comb begin
        for (int j = 0; j < 16; j++) m_words[j] = blk_q[511 - 32*j -: 32];
    end

    assign stg[0] = wk_q;

    for (genvar g = 0; g < R; g++) begin : g_step
        logic [5:0] step;
        step_ctl_t  ctl;
        assign step = cnt_q[5:0] + 6'(g);
        always_comb begin
            ctl = md4_ctl(step);
`ifdef MD_HASH_MD5_EN
            if (mode_q) ctl = md5_ctl(step);
`endif
        end
        md_step u_step (
            .st_i   (stg[g]),
            .m_i    (m_words[ctl.k]),
            .kc_i   (ctl.kc),
            .s_i    (ctl.s),
            .rnd_i  (ctl.rnd),
            .mode_i (md5_sel),
            .st_o   (stg[g+1])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        last_d  = last_q;
        ch_d    = ch_q;
        wk_d    = wk_q;
        dig_d   = dig_q;
        dv_d    = 1'b0;
`ifdef MD_HASH_MD5_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blk_d   = block_data;
                    last_d  = last;
                    cnt_d   = '0;
                    state_d = RUN;
                    // A continuation block keeps the chain and the mode of its message.
                    if (first) begin
                        ch_d = IV;
                        wk_d = IV;
`ifdef MD_HASH_MD5_EN
                        mode_d = mode;
`endif
                    end else begin
                        wk_d = ch_q;
                    end
                end
            end
            RUN: begin
                wk_d  = stg[R];
                cnt_d = cnt_q + 7'(R);
                if (cnt_d == limit) state_d = ADD;
            end
            ADD: begin
                for (int w = 0; w < 4; w++) ch_d[w] = ch_q[w] + wk_q[w];
                if (last_q) begin
                    dig_d = {bswap32(ch_d[0]), bswap32(ch_d[1]), bswap32(ch_d[2]), bswap32(ch_d[3])};
                    dv_d  = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
            ch_q    <= IV;
            wk_q    <= IV;
            dig_q   <= '0;
            dv_q    <= 1'b0;
`ifdef MD_HASH_MD5_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
            ch_q    <= ch_d;
            wk_q    <= wk_d;
            dig_q   <= dig_d;
            dv_q    <= dv_d;
`ifdef MD_HASH_MD5_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign digest       = dig_q;
    assign digest_valid = dv_q;

endmodule

// File: tb/tb_md_hash_engine.sv
// Scoreboard bench: one engine at one step per clock, one at four; a monitor per engine checks digests and latency.
module tb_md_hash_engine;

    localparam logic [127:0] MD4_E   = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
    localparam logic [127:0] MD4_ABC = 128'ha448017aaf21d8525fc10ae87aa6729d;
`ifdef MD_HASH_MD5_EN
    localparam logic [127:0] MD5_E   = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] MD5_ABC = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] MD5_A64 = 128'h014842d480b571495a4a0363793f7367;
`endif

    typedef struct {
        logic [127:0] dig;
        int           acc;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid1 = 1'b0, in_valid4 = 1'b0;
    logic         in_ready1, in_ready4;
    logic [511:0] block_data = '0;
    logic         first = 1'b0, last = 1'b0, mode = 1'b0;
    logic [127:0] digest1, digest4;
    logic         dv1, dv4, busy1, busy4;

    int   cyc = 0;
    int   checks = 0, fails = 0;
    int   pulses1 = 0, pulses4 = 0, exp_pulses1 = 0, exp_pulses4 = 0;
    exp_t q1[$], q4[$];
    exp_t e1, e4;
    logic [127:0] last_dig1 = '0, last_dig4 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    md_hash_engine #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .block_data(block_data), .first(first), .last(last), .mode(mode),
        .digest(digest1), .digest_valid(dv1), .busy(busy1));

    md_hash_engine #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .block_data(block_data), .first(first), .last(last), .mode(mode),
        .digest(digest4), .digest_valid(dv4), .busy(busy4));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic logic [511:0] mkblk(input logic [31:0] w0, input logic [31:0] wmid,
                                           input logic [31:0] w14, input logic [31:0] w15);
        logic [511:0] b;
        for (int j = 0; j < 16; j++) b[511 - 32*j -: 32] = (j == 0) ? w0 : (j == 14) ? w14 : (j == 15) ? w15 : wmid;
        return b;
    endfunction

    always @(negedge clk) begin
        if (!reset && dv1) begin
            pulses1++;
            if (q1.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_pulse_r1: digest %0h with nothing expected", digest1);
            end else begin
                e1 = q1.pop_front();
                chk("digest_r1", digest1, e1.dig);
                chk("latency_r1", 128'(cyc - e1.acc), 128'(e1.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && dv4) begin
            pulses4++;
            if (q4.size() == 0) begin
                checks++; fails++;
                $display("FAIL unexpected_pulse_r4: digest %0h with nothing expected", digest4);
            end else begin
                e4 = q4.pop_front();
                chk("digest_r4", digest4, e4.dig);
                chk("latency_r4", 128'(cyc - e4.acc), 128'(e4.lat));
            end
        end
    end

    // Holds in_valid until the selected engine accepts, then queues the expected digest.
    task automatic send(input int sel, input logic [511:0] d, input logic f, input logic l,
                        input logic m, input bit expect_dig, input logic [127:0] dig, input int lat);
        bit   ok;
        exp_t e;
        @(negedge clk);
        block_data = d; first = f; last = l; mode = m;
        if (sel == 1) in_valid1 = 1'b1; else in_valid4 = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            if ((sel == 1 && in_ready1) || (sel == 4 && in_ready4)) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (ok) @(negedge clk);
        in_valid1 = 1'b0; in_valid4 = 1'b0;
        if (!ok) begin
            checks++; fails++;
            $display("FAIL accept_timeout_r%0d: not accepted, want accept within 300 cycles", sel);
        end else if (expect_dig) begin
            e.dig = dig; e.acc = cyc; e.lat = lat;
            if (sel == 1) begin q1.push_back(e); exp_pulses1++; last_dig1 = dig; end
            else          begin q4.push_back(e); exp_pulses4++; last_dig4 = dig; end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q1.size() != 0 || q4.size() != 0) begin
            checks++; fails++;
            $display("FAIL drain: %0d/%0d digests outstanding, want 0", q1.size(), q4.size());
            q1.delete(); q4.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [511:0] b_empty, b_abc;
        int p_before;
        b_empty = mkblk(32'h00000080, 32'h0, 32'h0, 32'h0);
        b_abc   = mkblk(32'h80636261, 32'h0, 32'h00000018, 32'h0);

        repeat (3) @(negedge clk);
        chk("rst_in_ready_r1", 128'(in_ready1), 128'd1);
        chk("rst_busy_r1", 128'(busy1), 128'd0);
        chk("rst_dv_r1", 128'(dv1), 128'd0);
        chk("rst_digest_r1", digest1, 128'd0);
        chk("rst_in_ready_r4", 128'(in_ready4), 128'd1);
        chk("rst_digest_r4", digest4, 128'd0);
        reset = 1'b0;

        // Second block is presented during RUN and must be taken exactly once.
        send(1, b_empty, 1'b1, 1'b1, 1'b0, 1'b1, MD4_E, 49);
        chk("hold_in_ready_low", 128'(in_ready1), 128'd0);
        chk("hold_busy_high", 128'(busy1), 128'd1);
        send(1, b_abc, 1'b1, 1'b1, 1'b0, 1'b1, MD4_ABC, 49);
        send(4, b_abc, 1'b1, 1'b1, 1'b0, 1'b1, MD4_ABC, 13);
        send(4, b_empty, 1'b1, 1'b1, 1'b0, 1'b1, MD4_E, 13);
        drain();
        repeat (5) @(negedge clk);
        chk("digest_hold_r1", digest1, last_dig1);
        chk("digest_hold_r4", digest4, last_dig4);
        chk("idle_busy_r1", 128'(busy1), 128'd0);

`ifdef MD_HASH_MD5_EN
        send(1, b_empty, 1'b1, 1'b1, 1'b1, 1'b1, MD5_E, 65);
        send(4, b_abc, 1'b1, 1'b1, 1'b1, 1'b1, MD5_ABC, 17);
        send(1, b_abc, 1'b1, 1'b1, 1'b1, 1'b1, MD5_ABC, 65);
        send(1, b_abc, 1'b1, 1'b1, 1'b0, 1'b1, MD4_ABC, 49);
        drain();
        // Continuation block carries mode=0 on purpose: the message mode must persist.
        p_before = pulses1;
        send(1, mkblk(32'h61616161, 32'h61616161, 32'h61616161, 32'h61616161),
             1'b1, 1'b0, 1'b1, 1'b0, '0, 0);
        send(1, mkblk(32'h00000080, 32'h0, 32'h00000200, 32'h0), 1'b0, 1'b1, 1'b0, 1'b1, MD5_A64, 65);
        chk("no_pulse_mid_message", 128'(pulses1), 128'(p_before));
        send(4, b_empty, 1'b1, 1'b1, 1'b1, 1'b1, MD5_E, 17);
        drain();
`else
        send(1, b_abc, 1'b1, 1'b1, 1'b1, 1'b1, MD4_ABC, 49);
        send(4, b_empty, 1'b1, 1'b1, 1'b1, 1'b1, MD4_E, 13);
        drain();
`endif

        send(1, b_abc, 1'b1, 1'b1, 1'b0, 1'b0, '0, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_rst_busy", 128'(busy1), 128'd0);
        chk("midrun_rst_in_ready", 128'(in_ready1), 128'd1);
        chk("midrun_rst_digest", digest1, 128'd0);
        chk("midrun_rst_dv", 128'(dv1), 128'd0);
        reset = 1'b0;
        send(1, b_empty, 1'b1, 1'b1, 1'b0, 1'b1, MD4_E, 49);
        drain();
        repeat (60) @(negedge clk);

        chk("pulse_count_r1", 128'(pulses1), 128'(exp_pulses1));
        chk("pulse_count_r4", 128'(pulses4), 128'(exp_pulses4));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
